// File: rtl/dram_req_sequencer_if.sv
// Host request/response channel for the DRAM request sequencer.
// Latency: none (plain wires grouped for port hygiene).
// Backpressure: the host holds req_* stable while req_valid && !req_ready.
//
// Signals:
//   req_valid/req_ready  request handshake, accepted on req_valid && req_ready
//   req_we               1 = write, 0 = read
//   req_bank/row/col     target address
//   req_wdata            write data bit
//   rsp_valid            one-cycle read response pulse
//   rsp_rdata            read data bit, held until the next read response
interface dram_req_sequencer_if #(
    parameter int BW = 3,
    parameter int RW = 7,
    parameter int CW = 3
) ();
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [BW-1:0] req_bank;
    logic [RW-1:0] req_row;
    logic [CW-1:0] req_col;
    logic          req_wdata;
    logic          rsp_valid;
    logic          rsp_rdata;

    modport master (
        output req_valid, req_we, req_bank, req_row, req_col, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_bank, req_row, req_col, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/dram_req_sequencer.sv
// Initiator for a single-bit DRAM bank/row-buffer array; tracks open rows so read hits skip activation.
// Latency from accept edge: write ready in cycle 2, read hit rsp in cycle 3, read miss rsp in cycle 5.
// Backpressure: req_ready is high only in IDLE; one request in flight, no response backpressure.
//
// Ports:
//   clk, rst_b            clock (posedge), asynchronous active-low reset
//   host (slave)          request valid/ready channel and read response
//   bank_rw               1 = memory writes data into array[bank_id][rowid][colid] at posedge
//   buffer_rw             1 = memory tri-states data (activate / write), 0 = memory drives data
//   bank_id/rowid/colid   registered address to the memory
//   data                  shared data line, driven here only in WR
//   hit_cnt/miss_cnt      saturating read hit / miss (activation) counters
module dram_req_sequencer #(
    parameter int NUM_OF_BANKS = 8,
    parameter int NUM_OF_ROWS  = 128,
    parameter int NUM_OF_COLS  = 8,
    parameter int CNT_WIDTH    = 16,
    localparam int BW = $clog2(NUM_OF_BANKS),
    localparam int RW = $clog2(NUM_OF_ROWS),
    localparam int CW = $clog2(NUM_OF_COLS)
) (
    input  logic                 clk,
    input  logic                 rst_b,
    dram_req_sequencer_if.slave  host,
    output logic                 bank_rw,
    output logic                 buffer_rw,
    output logic [BW-1:0]        bank_id,
    output logic [RW-1:0]        rowid,
    output logic [CW-1:0]        colid,
    inout  wire                  data,
    output logic [CNT_WIDTH-1:0] hit_cnt,
    output logic [CNT_WIDTH-1:0] miss_cnt
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WR   = 3'd1,
        ACT1 = 3'd2,
        ACT2 = 3'd3,
        RD   = 3'd4,
        CAP  = 3'd5
    } state_t;

    state_t state;
    state_t state_nxt;

    // Open-row tracking, one entry per bank.
    logic [NUM_OF_BANKS-1:0] open_valid;
    logic [RW-1:0]           open_row [NUM_OF_BANKS];

    logic wdata_q;
    logic data_oe;
    logic rsp_valid_q;
    logic rsp_rdata_q;

    logic accept;
    logic req_hit;
    logic cur_open_match;

    assign host.req_ready = (state == IDLE);
    assign host.rsp_valid = rsp_valid_q;
    assign host.rsp_rdata = rsp_rdata_q;

    assign accept = host.req_valid && host.req_ready;

    // Hit lookup uses the incoming request address (IDLE only).
    assign req_hit = open_valid[host.req_bank] &&
                     (open_row[host.req_bank] == host.req_row);

    // Same lookup against the latched address, used by WR to invalidate a stale buffer.
    assign cur_open_match = open_valid[bank_id] && (open_row[bank_id] == rowid);

    // Only the WR state drives the shared line; everywhere else the memory owns it or it floats.
    assign data = data_oe ? wdata_q : 1'bz;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (host.req_we) begin
                        state_nxt = WR;
                    end else if (req_hit) begin
                        state_nxt = RD;
                    end else begin
                        state_nxt = ACT1;
                    end
                end
            end
            WR:      state_nxt = IDLE;
            ACT1:    state_nxt = ACT2;
            ACT2:    state_nxt = RD;
            RD:      state_nxt = CAP;
            CAP:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state       <= IDLE;
            bank_rw     <= 1'b0;
            buffer_rw   <= 1'b0;
            data_oe     <= 1'b0;
            bank_id     <= '0;
            rowid       <= '0;
            colid       <= '0;
            wdata_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 1'b0;
            open_valid  <= '0;
            for (int i = 0; i < NUM_OF_BANKS; i++) begin
                open_row[i] <= '0;
            end
            hit_cnt     <= '0;
            miss_cnt    <= '0;
        end else begin
            state <= state_nxt;

            // Memory-side strobes are registered from the next state so they
            // line up exactly with the state they belong to.
            bank_rw   <= (state_nxt == WR);
            buffer_rw <= (state_nxt == WR) || (state_nxt == ACT1) || (state_nxt == ACT2);
            data_oe   <= (state_nxt == WR);

            // Response pulse lands in the IDLE cycle right after CAP.
            rsp_valid_q <= (state == CAP);
            if (state == CAP) begin
                rsp_rdata_q <= data;
            end

            if (accept) begin
                bank_id <= host.req_bank;
                rowid   <= host.req_row;
                colid   <= host.req_col;
                wdata_q <= host.req_wdata;
                if (!host.req_we) begin
                    if (req_hit) begin
                        if (hit_cnt != '1) begin
                            hit_cnt <= hit_cnt + CNT_WIDTH'(1);
                        end
                    end else begin
                        if (miss_cnt != '1) begin
                            miss_cnt <= miss_cnt + CNT_WIDTH'(1);
                        end
                    end
                end
            end

            // A write goes to the array, not the row buffer, so an open copy of
            // that row is now stale and must be re-activated on the next read.
            if ((state == WR) && cur_open_match) begin
                open_valid[bank_id] <= 1'b0;
            end

            // Row is in the bank buffer after the second activation edge.
            if (state == ACT2) begin
                open_row[bank_id]   <= rowid;
                open_valid[bank_id] <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dram_req_sequencer.sv
// Bench for dram_req_sequencer: table of directed requests against a behavioural
// bank/row-buffer memory, plus hand sequences for response hold and mid-activation reset.
module tb_dram_req_sequencer;

    localparam int NB    = 8;
    localparam int NR    = 128;
    localparam int NC    = 8;
    localparam int CNT_W = 3;

    logic             clk;
    logic             rst_b;
    logic             bank_rw;
    logic             buffer_rw;
    logic [2:0]       bank_id;
    logic [6:0]       rowid;
    logic [2:0]       colid;
    wire              data;
    logic [CNT_W-1:0] hit_cnt;
    logic [CNT_W-1:0] miss_cnt;

    int total = 0;
    int bad   = 0;
    int drv_err = 0;
    int strobe_err = 0;

    dram_req_sequencer_if #(.BW(3), .RW(7), .CW(3)) host_if ();

    dram_req_sequencer #(
        .NUM_OF_BANKS(NB),
        .NUM_OF_ROWS (NR),
        .NUM_OF_COLS (NC),
        .CNT_WIDTH   (CNT_W)
    ) dut (
        .clk      (clk),
        .rst_b    (rst_b),
        .host     (host_if),
        .bank_rw  (bank_rw),
        .buffer_rw(buffer_rw),
        .bank_id  (bank_id),
        .rowid    (rowid),
        .colid    (colid),
        .data     (data),
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural memory: array, one row buffer per bank, registered read bit.
    logic [NC-1:0] mem  [NB][NR];
    logic [NC-1:0] bufr [NB];
    logic          rd_q;

    initial begin
        for (int b = 0; b < NB; b++) begin
            bufr[b] = '0;
            for (int r = 0; r < NR; r++) mem[b][r] = '0;
        end
        rd_q = 1'b0;
    end

    always @(posedge clk) begin
        if (bank_rw) mem[bank_id][rowid][colid] <= data;
        if (buffer_rw && !bank_rw) bufr[bank_id] <= mem[bank_id][rowid];
        rd_q <= bufr[bank_id][colid];
    end

    assign data = buffer_rw ? 1'bz : rd_q;

    // Whenever the memory owns the line, the line must carry the memory's bit.
    always @(negedge clk) begin
        if (rst_b && !buffer_rw && (data !== rd_q)) drv_err++;
        if (rst_b && bank_rw && !buffer_rw) strobe_err++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Issue one request starting at a negedge; returns at the negedge of the
    // response cycle (read) or first ready cycle (write).
    task automatic issue(input logic we, input logic [2:0] b, input logic [6:0] r,
                         input logic [2:0] c, input logic wd,
                         output int lat, output int acts, output int rd,
                         output int addr_ok, output int wr_strobe, output int wr_data);
        int n;
        n = 0;
        lat = -1; acts = 0; rd = -1; addr_ok = 0; wr_strobe = 0; wr_data = -1;
        host_if.req_valid = 1'b1;
        host_if.req_we    = we;
        host_if.req_bank  = b;
        host_if.req_row   = r;
        host_if.req_col   = c;
        host_if.req_wdata = wd;
        while (!host_if.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("ready_wait_timeout", 0, 1);
        @(posedge clk);
        @(negedge clk);
        host_if.req_valid = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            if (k == 1) begin
                addr_ok   = (bank_id == b && rowid == r && colid == c) ? 1 : 0;
                wr_strobe = int'(bank_rw);
                wr_data   = int'(data);
            end
            if (!we && host_if.rsp_valid) begin
                lat = k;
                rd  = int'(host_if.rsp_rdata);
                break;
            end
            if (we && host_if.req_ready) begin
                lat = k;
                break;
            end
            if (buffer_rw && !bank_rw) acts++;
            @(negedge clk);
        end
    endtask

    typedef struct {
        logic       we;
        logic [2:0] b;
        logic [6:0] r;
        logic [2:0] c;
        logic       wd;
        int         lat;
        int         acts;
        int         rd;
        int         hit;
        int         miss;
    } vec_t;

    vec_t vecs [22];

    initial begin
        int lat, acts, rd, addr_ok, wr_strobe, wr_data;

        //            we    b  r    c  wd  lat acts rd hit miss
        vecs[0]  = '{1'b0, 0, 0,   0, 0,  5,  2,  0, 0, 1};
        vecs[1]  = '{1'b1, 3, 5,   2, 1,  2,  0,  0, 0, 1};
        vecs[2]  = '{1'b0, 3, 5,   2, 0,  5,  2,  1, 0, 2};
        vecs[3]  = '{1'b0, 3, 5,   2, 0,  3,  0,  1, 1, 2};
        vecs[4]  = '{1'b1, 3, 5,   2, 0,  2,  0,  0, 1, 2};
        vecs[5]  = '{1'b0, 3, 5,   2, 0,  5,  2,  0, 1, 3};
        vecs[6]  = '{1'b1, 1, 7,   4, 1,  2,  0,  0, 1, 3};
        vecs[7]  = '{1'b1, 2, 9,   6, 1,  2,  0,  0, 1, 3};
        vecs[8]  = '{1'b0, 1, 7,   4, 0,  5,  2,  1, 1, 4};
        vecs[9]  = '{1'b0, 2, 9,   6, 0,  5,  2,  1, 1, 5};
        vecs[10] = '{1'b0, 1, 7,   4, 0,  3,  0,  1, 2, 5};
        vecs[11] = '{1'b0, 2, 9,   6, 0,  3,  0,  1, 3, 5};
        vecs[12] = '{1'b0, 1, 7,   0, 0,  3,  0,  0, 4, 5};
        vecs[13] = '{1'b1, 1, 8,   0, 1,  2,  0,  0, 4, 5};
        vecs[14] = '{1'b0, 1, 7,   4, 0,  3,  0,  1, 5, 5};
        vecs[15] = '{1'b1, 7, 127, 7, 1,  2,  0,  0, 5, 5};
        vecs[16] = '{1'b0, 7, 127, 7, 0,  5,  2,  1, 5, 6};
        vecs[17] = '{1'b0, 7, 127, 7, 0,  3,  0,  1, 6, 6};
        vecs[18] = '{1'b0, 7, 127, 7, 0,  3,  0,  1, 7, 6};
        vecs[19] = '{1'b0, 7, 127, 7, 0,  3,  0,  1, 7, 6};
        vecs[20] = '{1'b0, 0, 1,   0, 0,  5,  2,  0, 7, 7};
        vecs[21] = '{1'b0, 0, 2,   0, 0,  5,  2,  0, 7, 7};

        rst_b = 1'b0;
        host_if.req_valid = 1'b0;
        host_if.req_we    = 1'b0;
        host_if.req_bank  = '0;
        host_if.req_row   = '0;
        host_if.req_col   = '0;
        host_if.req_wdata = 1'b0;
        repeat (3) @(negedge clk);
        rst_b = 1'b1;
        @(negedge clk);

        check("rst_ready",     int'(host_if.req_ready), 1);
        check("rst_bank_rw",   int'(bank_rw), 0);
        check("rst_buffer_rw", int'(buffer_rw), 0);
        check("rst_addr",      int'({bank_id, rowid, colid}), 0);
        check("rst_rsp_valid", int'(host_if.rsp_valid), 0);
        check("rst_rsp_rdata", int'(host_if.rsp_rdata), 0);
        check("rst_hit_cnt",   int'(hit_cnt), 0);
        check("rst_miss_cnt",  int'(miss_cnt), 0);

        for (int i = 0; i < 22; i++) begin
            issue(vecs[i].we, vecs[i].b, vecs[i].r, vecs[i].c, vecs[i].wd,
                  lat, acts, rd, addr_ok, wr_strobe, wr_data);
            check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
            check($sformatf("v%0d_addr", i), addr_ok, 1);
            if (vecs[i].we) begin
                check($sformatf("v%0d_wr_strobe", i), wr_strobe, 1);
                check($sformatf("v%0d_wr_data", i), wr_data, int'(vecs[i].wd));
            end else begin
                check($sformatf("v%0d_act_cycles", i), acts, vecs[i].acts);
                check($sformatf("v%0d_rdata", i), rd, vecs[i].rd);
            end
            check($sformatf("v%0d_hit_cnt", i), int'(hit_cnt), vecs[i].hit);
            check($sformatf("v%0d_miss_cnt", i), int'(miss_cnt), vecs[i].miss);
        end

        // Read returning 1, then a write: response data must hold, pulse must drop.
        issue(1'b0, 3'd7, 7'd127, 3'd7, 1'b0, lat, acts, rd, addr_ok, wr_strobe, wr_data);
        check("hold_read_rdata", rd, 1);
        @(negedge clk);
        check("rsp_pulse_one_cycle", int'(host_if.rsp_valid), 0);
        issue(1'b1, 3'd6, 7'd0, 3'd0, 1'b0, lat, acts, rd, addr_ok, wr_strobe, wr_data);
        check("hold_after_write_rdata", int'(host_if.rsp_rdata), 1);
        check("hold_after_write_valid", int'(host_if.rsp_valid), 0);

        // Open (b4,r3), then reset in the ACT2 cycle of another miss.
        issue(1'b0, 3'd4, 7'd3, 3'd1, 1'b0, lat, acts, rd, addr_ok, wr_strobe, wr_data);
        check("pre_reset_open_latency", lat, 5);
        host_if.req_valid = 1'b1;
        host_if.req_we    = 1'b0;
        host_if.req_bank  = 3'd5;
        host_if.req_row   = 7'd2;
        host_if.req_col   = 3'd0;
        @(posedge clk);
        @(negedge clk);
        host_if.req_valid = 1'b0;
        check("act1_buffer_rw", int'(buffer_rw), 1);
        @(negedge clk);
        check("act2_buffer_rw", int'(buffer_rw), 1);
        check("act2_not_ready", int'(host_if.req_ready), 0);
        rst_b = 1'b0;
        #1;
        check("midrst_buffer_rw", int'(buffer_rw), 0);
        check("midrst_ready",     int'(host_if.req_ready), 1);
        check("midrst_addr",      int'({bank_id, rowid, colid}), 0);
        check("midrst_miss_cnt",  int'(miss_cnt), 0);
        @(negedge clk);
        rst_b = 1'b1;
        @(negedge clk);
        check("post_rst_idle_buffer_rw", int'(buffer_rw), 0);
        check("post_rst_rsp_valid", int'(host_if.rsp_valid), 0);
        issue(1'b0, 3'd4, 7'd3, 3'd1, 1'b0, lat, acts, rd, addr_ok, wr_strobe, wr_data);
        check("post_rst_reread_latency", lat, 5);
        check("post_rst_reread_acts", acts, 2);
        check("post_rst_reread_rdata", rd, 0);
        check("post_rst_miss_cnt", int'(miss_cnt), 1);
        check("post_rst_hit_cnt", int'(hit_cnt), 0);

        check("dut_drive_when_memory_owns", drv_err, 0);
        check("bank_rw_without_buffer_rw", strobe_err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
